noc_input_requester: RTL

- Input-port side of the router's switch allocation; the requester end of the per-output-port 5-way hold-until-release arbiters.
- Pops flits from its input FIFO (first-word-fall-through), XY-routes each head flit, and raises one of five one-hot requests.
- Waits for the matching grant, then forwards every flit of the packet. Drops the request after the tail flit so the arbiter returns to idle.

---
 rtl/noc_pkg.sv | 18 +
 rtl/noc_xy_route.sv | 23 ++
 rtl/noc_input_requester.sv | 71 +++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit type codes, output port indices and requester state encodings shared by the router input side.
package noc_pkg;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;
  localparam int P_LOCAL = 0;
  localparam int P_EAST  = 1;
  localparam int P_WEST  = 2;
  localparam int P_NORTH = 3;
  localparam int P_SOUTH = 4;
  localparam int N_PORTS = 5;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } req_state_t;
endpackage

// File: rtl/noc_xy_route.sv
// noc_xy_route: combinational XY dimension-order route from a head flit's destination field to a one-hot output port.
module noc_xy_route
  import noc_pkg::*;
#(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  logic [X_W+Y_W-1:0] dest,
  input  logic [X_W-1:0]     local_x,
  input  logic [Y_W-1:0]     local_y,
  output logic [N_PORTS-1:0] port
);
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  assign dx = dest[X_W+Y_W-1:Y_W];
  assign dy = dest[Y_W-1:0];
  always_comb
    port = dx > local_x ? N_PORTS'(1) << P_EAST  :
           dx < local_x ? N_PORTS'(1) << P_WEST  :
           dy > local_y ? N_PORTS'(1) << P_NORTH :
           dy < local_y ? N_PORTS'(1) << P_SOUTH :
                          N_PORTS'(1) << P_LOCAL;
endmodule

// File: rtl/noc_input_requester.sv
// noc_input_requester: routes each head flit from the input FIFO, requests the output arbiter,
// and forwards the whole packet while the grant is held; releases the request after the tail.
module noc_input_requester
  import noc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int X_W     = 2,
  parameter int Y_W     = 2,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [4:0]        req,
  input  logic [4:0]        gnt,
  input  logic              out_ready,
  output logic [DATA_W-1:0] flit_out,
  output logic              flit_valid,
  output logic [15:0]       pkt_cnt,
  output logic              err
);
  req_state_t state;
  logic [4:0] port_q, route;
  logic [1:0] ft;
  logic is_head, is_tail, gnt_sel, xfer, orphan;
  noc_xy_route #(.X_W(X_W), .Y_W(Y_W)) u_route (
    .dest(fifo_dout[X_W+Y_W-1:0]),
    .local_x(X_W'(LOCAL_X)),
    .local_y(Y_W'(LOCAL_Y)),
    .port(route)
  );
  assign ft = fifo_dout[DATA_W-1 -: 2];
  assign is_head = ft == FT_HEAD || ft == FT_SINGLE;
  assign is_tail = ft == FT_TAIL || ft == FT_SINGLE;
  // Only the grant of our own requested port matters; others and stale grants outside XFER are ignored.
  assign gnt_sel = |(gnt & port_q);
  assign xfer = state == S_XFER && gnt_sel && !fifo_empty && out_ready;
  assign orphan = state == S_IDLE && !fifo_empty && !is_head;
  assign fifo_rd_en = !rst && (xfer || orphan);
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      req <= '0;
      port_q <= '0;
      flit_out <= '0;
      flit_valid <= 1'b0;
      pkt_cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= orphan || (state == S_XFER && !gnt_sel);
      flit_valid <= xfer;
      if (xfer) flit_out <= fifo_dout;
      case (state)
        S_IDLE: if (!fifo_empty && is_head) begin
          port_q <= route;
          req <= route;
          state <= S_REQ;
        end
        S_REQ: if (gnt_sel) state <= S_XFER;
        S_XFER: if (xfer && is_tail) begin
          req <= '0;
          state <= S_IDLE;
          pkt_cnt <= pkt_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
